// File: rtl/axi_wr_seq.sv
// Single-outstanding AXI3 write sequencer: takes one burst command, issues AW,
// streams din beats onto W, waits for a matching B response and reports it.
module axi_wr_seq (
    input  logic        aclk,
    input  logic        arst,
    // command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    // write-data stream
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    input  logic [3:0]  din_strb,
    // AW channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    // W channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // B channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    // status
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        id_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] beat_cnt;

    logic accept;
    logic beat_fire;
    logic resp_hit;

    assign awsize  = 3'b010;
    assign awburst = 2'b01;

    assign cmd_ready = (state == S_IDLE);
    assign awvalid   = (state == S_ADDR);
    assign bready    = (state == S_RESP);

    // W is a combinational pass-through of the din stream while in DATA.
    assign wvalid    = (state == S_DATA) && din_valid;
    assign din_ready = (state == S_DATA) && wready;
    assign wlast     = (state == S_DATA) && (beat_cnt == awlen);
    assign wid       = awid;
    assign wdata     = din_data;
    assign wstrb     = din_strb;

    assign accept    = cmd_valid && cmd_ready;
    assign beat_fire = wvalid && wready;
    assign resp_hit  = bready && bvalid && (bid == awid);

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept)               state_nx = S_ADDR;
            S_ADDR: if (awready)              state_nx = S_DATA;
            S_DATA: if (beat_fire && wlast)   state_nx = S_RESP;
            S_RESP: if (resp_hit)             state_nx = S_IDLE;
            default:                          state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= S_IDLE;
            beat_cnt  <= 4'd0;
            awid      <= 4'd0;
            awaddr    <= 32'd0;
            awlen     <= 4'd0;
            done      <= 1'b0;
            done_resp <= 2'b00;
            id_err    <= 1'b0;
        end else begin
            state  <= state_nx;
            done   <= 1'b0;
            id_err <= 1'b0;

            if (accept) begin
                awid     <= cmd_id;
                awaddr   <= cmd_addr;
                awlen    <= cmd_len;
                beat_cnt <= 4'd0;
            end

            // Counter holds on the last beat so it never runs past the burst length.
            if (beat_fire && !wlast)
                beat_cnt <= beat_cnt + 4'd1;

            if (bready && bvalid) begin
                if (bid == awid) begin
                    done      <= 1'b1;
                    done_resp <= bresp;
                end else begin
                    id_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_seq.sv
// Directed bench for axi_wr_seq: inputs driven on the falling edge, outputs
// checked 1 ns later, well away from the rising edge.
module tb_axi_wr_seq;

    logic        aclk;
    logic        arst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic [3:0]  din_strb;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        done;
    logic [1:0]  done_resp;
    logic        id_err;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] beats[$];
    int          done_cnt   = 0;
    int          id_err_cnt = 0;

    axi_wr_seq dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_strb(din_strb),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .done(done), .done_resp(done_resp), .id_err(id_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (wvalid && wready) beats.push_back(wdata);
        if (done)   done_cnt++;
        if (id_err) id_err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        cyc(); cyc();
        arst = 1'b0;
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        vectors++; if (awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got %b want 0", awvalid); end
        vectors++; if (wvalid !== 1'b0 || wlast !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL reset_w got wvalid=%b wlast=%b din_ready=%b want 0/0/0", wvalid, wlast, din_ready); end
        vectors++; if (bready !== 1'b0 || done !== 1'b0 || id_err !== 1'b0) begin errors++; $display("FAIL reset_b got bready=%b done=%b id_err=%b want 0/0/0", bready, done, id_err); end
        vectors++; if (done_resp !== 2'b00) begin errors++; $display("FAIL reset_done_resp got %b want 00", done_resp); end
        vectors++; if (awaddr !== 32'd0 || awid !== 4'd0 || awlen !== 4'd0 || wid !== 4'd0) begin errors++; $display("FAIL reset_aw_regs got addr=%h id=%h len=%h wid=%h want zeros", awaddr, awid, awlen, wid); end
        vectors++; if (awsize !== 3'b010 || awburst !== 2'b01) begin errors++; $display("FAIL const_size_burst got %b/%b want 010/01", awsize, awburst); end
    endtask

    // Zero-wait transaction with cycle-exact checks; done expected at accept+len+4.
    task automatic run_simple(input logic [31:0] a, input logic [3:0] l, input logic [3:0] id, input logic [1:0] r);
        cyc();
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = id;
        awready = 1'b1; wready = 1'b1; din_valid = 1'b1;
        bvalid = 1'b1; bid = id; bresp = r;
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL simple_accept cmd_ready got %b want 1", cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        #1;
        vectors++; if (awvalid !== 1'b1 || awaddr !== a || awlen !== l || awid !== id) begin errors++; $display("FAIL simple_aw got v=%b addr=%h len=%0d id=%0d want 1/%h/%0d/%0d", awvalid, awaddr, awlen, awid, a, l, id); end
        vectors++; if (wvalid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL simple_addr_phase got wvalid=%b cmd_ready=%b want 0/0", wvalid, cmd_ready); end
        for (int i = 0; i <= int'(l); i++) begin
            cyc();
            din_data = 32'hA000_0000 + 32'(i); din_strb = 4'hF;
            #1;
            vectors++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || din_ready !== 1'b1) begin errors++; $display("FAIL simple_beat%0d got awvalid=%b wvalid=%b din_ready=%b want 0/1/1", i, awvalid, wvalid, din_ready); end
            vectors++; if (wlast !== (i == int'(l)) || wid !== id || wdata !== 32'hA000_0000 + 32'(i) || wstrb !== 4'hF) begin errors++; $display("FAIL simple_beat%0d_payload got wlast=%b wid=%0d wdata=%h", i, wlast, wid, wdata); end
        end
        cyc();
        #1;
        vectors++; if (bready !== 1'b1 || wvalid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL simple_resp got bready=%b wvalid=%b done=%b want 1/0/0", bready, wvalid, done); end
        cyc();
        #1;
        vectors++; if (done !== 1'b1 || done_resp !== r || cmd_ready !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL simple_done got done=%b resp=%b cmd_ready=%b bready=%b want 1/%b/1/0", done, done_resp, cmd_ready, bready, r); end
        cyc();
        bvalid = 1'b0; din_valid = 1'b0;
        #1;
        vectors++; if (done !== 1'b0 || done_resp !== r) begin errors++; $display("FAIL simple_done_pulse got done=%b resp=%b want 0/%b", done, done_resp, r); end
    endtask

    task automatic test_basic();
        run_simple(32'h0000_1000, 4'd3, 4'd5, 2'b00);
    endtask

    task automatic test_len0_aw_delay();
        cyc();
        cmd_valid = 1'b1; cmd_addr = 32'h0000_2000; cmd_len = 4'd0; cmd_id = 4'd3;
        awready = 1'b0; wready = 1'b1; din_valid = 1'b0; bvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            cmd_valid = 1'b0;
            awready = (c == 3);
            #1;
            vectors++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_2000 || awlen !== 4'd0 || awid !== 4'd3) begin errors++; $display("FAIL len0_aw_hold%0d got v=%b addr=%h len=%0d id=%0d want 1/00002000/0/3", c, awvalid, awaddr, awlen, awid); end
        end
        cyc();
        awready = 1'b0; din_valid = 1'b1; din_data = 32'h5555_AAAA; din_strb = 4'h3;
        #1;
        vectors++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || wlast !== 1'b1 || wdata !== 32'h5555_AAAA || wstrb !== 4'h3) begin errors++; $display("FAIL len0_beat got awvalid=%b wvalid=%b wlast=%b wdata=%h wstrb=%h", awvalid, wvalid, wlast, wdata, wstrb); end
        cyc();
        din_valid = 1'b0; bvalid = 1'b1; bid = 4'd3; bresp = 2'b01;
        #1;
        vectors++; if (bready !== 1'b1 || wvalid !== 1'b0 || wlast !== 1'b0) begin errors++; $display("FAIL len0_resp got bready=%b wvalid=%b wlast=%b want 1/0/0", bready, wvalid, wlast); end
        cyc();
        bvalid = 1'b0;
        #1;
        vectors++; if (done !== 1'b1 || done_resp !== 2'b01) begin errors++; $display("FAIL len0_done got done=%b resp=%b want 1/01", done, done_resp); end
        cyc();
        #1;
        vectors++; if (done !== 1'b0 || done_resp !== 2'b01) begin errors++; $display("FAIL len0_resp_hold got done=%b resp=%b want 0/01", done, done_resp); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        beats.delete();
        cyc();
        cmd_valid = 1'b1; cmd_addr = 32'h0000_3000; cmd_len = 4'd7; cmd_id = 4'd5;
        awready = 1'b1; wready = 1'b0; din_valid = 1'b0; bvalid = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            cyc();
            wready    = (c % 2 == 0);
            din_valid = (c % 3 != 2);
            din_data  = 32'hD000 + 32'(idx);
            din_strb  = 4'(idx);
            #1;
            vectors++; if (wvalid !== din_valid || din_ready !== wready) begin errors++; $display("FAIL bp_passthru c=%0d got wvalid=%b din_ready=%b want %b/%b", c, wvalid, din_ready, din_valid, wready); end
            vectors++; if (wlast !== (idx == 7) || wdata !== 32'hD000 + 32'(idx)) begin errors++; $display("FAIL bp_beat c=%0d got wlast=%b wdata=%h want %b/%h", c, wlast, wdata, idx == 7, 32'hD000 + 32'(idx)); end
            if (din_valid && wready) idx++;
        end
        vectors++; if (idx != 8) begin errors++; $display("FAIL bp_timeout got %0d beats want 8", idx); end
        cyc();
        din_valid = 1'b0; wready = 1'b1; bvalid = 1'b1; bid = 4'd5; bresp = 2'b00;
        #1;
        vectors++; if (bready !== 1'b1 || wvalid !== 1'b0) begin errors++; $display("FAIL bp_resp got bready=%b wvalid=%b want 1/0", bready, wvalid); end
        cyc();
        bvalid = 1'b0;
        #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done); end
        vectors++; if (beats.size() != 8) begin errors++; $display("FAIL bp_beat_count got %0d want 8", beats.size()); end
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            vectors++; if (beats[i] !== 32'hD000 + 32'(i)) begin errors++; $display("FAIL bp_order beat%0d got %h want %h", i, beats[i], 32'hD000 + 32'(i)); end
        end
    endtask

    task automatic test_id_mismatch();
        int err0 = id_err_cnt;
        cyc();
        cmd_valid = 1'b1; cmd_addr = 32'h0000_4400; cmd_len = 4'd0; cmd_id = 4'd5;
        awready = 1'b1; wready = 1'b1; din_valid = 1'b1; bvalid = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        din_data = 32'h1234_5678;
        cyc();
        din_valid = 1'b0; bvalid = 1'b1; bid = 4'd2; bresp = 2'b11;
        #1;
        vectors++; if (bready !== 1'b1 || id_err !== 1'b0) begin errors++; $display("FAIL idm_resp got bready=%b id_err=%b want 1/0", bready, id_err); end
        cyc();
        bid = 4'd5; bresp = 2'b10;
        #1;
        vectors++; if (id_err !== 1'b1 || done !== 1'b0 || bready !== 1'b1) begin errors++; $display("FAIL idm_err got id_err=%b done=%b bready=%b want 1/0/1", id_err, done, bready); end
        cyc();
        bvalid = 1'b0;
        #1;
        vectors++; if (done !== 1'b1 || done_resp !== 2'b10 || id_err !== 1'b0) begin errors++; $display("FAIL idm_done got done=%b resp=%b id_err=%b want 1/10/0", done, done_resp, id_err); end
        cyc();
        #1;
        vectors++; if (id_err_cnt - err0 != 1) begin errors++; $display("FAIL idm_pulse_count got %0d want 1", id_err_cnt - err0); end
    endtask

    task automatic test_reset_mid();
        int done0;
        cyc();
        cmd_valid = 1'b1; cmd_addr = 32'h0000_6000; cmd_len = 4'd3; cmd_id = 4'd6;
        awready = 1'b1; wready = 1'b1; din_valid = 1'b1; bvalid = 1'b1; bid = 4'd6; bresp = 2'b00;
        cyc();
        cmd_valid = 1'b0;
        cyc(); cyc();
        cyc();
        arst = 1'b1;
        #1;
        vectors++; if (wvalid !== 1'b1 || wlast !== 1'b0) begin errors++; $display("FAIL rst_mid_beat2 got wvalid=%b wlast=%b want 1/0", wvalid, wlast); end
        done0 = done_cnt;
        cyc();
        arst = 1'b0;
        #1;
        vectors++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || din_ready !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL rst_mid_valids got aw=%b w=%b dr=%b br=%b want 0000", awvalid, wvalid, din_ready, bready); end
        vectors++; if (cmd_ready !== 1'b1 || done !== 1'b0 || awaddr !== 32'd0) begin errors++; $display("FAIL rst_mid_idle got cmd_ready=%b done=%b awaddr=%h want 1/0/0", cmd_ready, done, awaddr); end
        cyc(); cyc(); cyc();
        #1;
        vectors++; if (done_cnt != done0 || bready !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got %0d done pulses bready=%b want 0/0", done_cnt - done0, bready); end
        run_simple(32'h0000_7000, 4'd2, 4'd9, 2'b11);
    endtask

    task automatic test_busy();
        cyc();
        cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_len = 4'd1; cmd_id = 4'd1;
        awready = 1'b1; wready = 1'b1; din_valid = 1'b1; bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        cyc();
        cmd_addr = 32'h0000_5000; cmd_len = 4'd0; cmd_id = 4'd2;
        #1;
        vectors++; if (cmd_ready !== 1'b0 || awaddr !== 32'h0000_4000 || awid !== 4'd1) begin errors++; $display("FAIL busy_addr got cmd_ready=%b awaddr=%h awid=%0d want 0/00004000/1", cmd_ready, awaddr, awid); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            vectors++; if (cmd_ready !== 1'b0 || awaddr !== 32'h0000_4000) begin errors++; $display("FAIL busy_hold%0d got cmd_ready=%b awaddr=%h want 0/00004000", c, cmd_ready, awaddr); end
        end
        cyc();
        bid = 4'd2;
        #1;
        vectors++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_done got done=%b cmd_ready=%b want 1/1", done, cmd_ready); end
        cyc();
        cmd_valid = 1'b0;
        #1;
        vectors++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_5000 || awid !== 4'd2 || awlen !== 4'd0) begin errors++; $display("FAIL busy_second_aw got v=%b addr=%h id=%0d len=%0d want 1/00005000/2/0", awvalid, awaddr, awid, awlen); end
        cyc();
        #1;
        vectors++; if (wvalid !== 1'b1 || wlast !== 1'b1 || wid !== 4'd2) begin errors++; $display("FAIL busy_second_beat got wvalid=%b wlast=%b wid=%0d want 1/1/2", wvalid, wlast, wid); end
        cyc();
        cyc();
        bvalid = 1'b0; din_valid = 1'b0;
        #1;
        vectors++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_second_done got done=%b cmd_ready=%b want 1/1", done, cmd_ready); end
    endtask

    initial begin
        arst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        din_valid = 1'b0; din_data = '0; din_strb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        test_reset();
        test_basic();
        test_len0_aw_delay();
        test_backpressure();
        test_id_mismatch();
        test_reset_mid();
        test_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
